uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_tx_core.sv | 138 +++++++++++++
 tb/tb_uart_tx_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding and 8N1 frame constants.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue with wrap-bit pointers so full and empty are distinguishable.
// Latency: a pushed byte is visible on pop_data/empty the cycle after the push.
// Backpressure: push is ignored while full, pop is ignored while empty.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             push_en;
    logic             pop_en;

    // Full is judged on the pre-edge pointers, so a same-cycle pop never frees room for a push.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter fed from a small byte FIFO; baud_div latched per frame.
// Latency: byte accepted in cycle N is popped in N+1, start bit on uart_sout from N+2.
// Backpressure: tx_ready = !full (registered state only); frames run back to back.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [15:0] baud_div,
    output logic        uart_sout,
    output logic        busy
);

    tx_state_e              state;
    tx_state_e              state_n;
    logic [15:0]            cnt;
    logic [15:0]            cnt_n;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_idx_n;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   shreg_n;
    logic [15:0]            baud_q;
    logic [15:0]            baud_n;
    logic                   sout_n;
    logic                   busy_n;
    logic                   bit_end;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_dat;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dat),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign bit_end  = (cnt == baud_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            baud_q    <= '0;
            uart_sout <= IDLE_LEVEL;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            baud_q    <= baud_n;
            uart_sout <= sout_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n  = START;
                    fifo_pop = 1'b1;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'(DATA_BITS - 1)) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        state_n  = START;
                        fifo_pop = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        baud_n    = baud_q;
        if (fifo_pop) begin
            shreg_n   = fifo_dat;
            baud_n    = baud_div;
            cnt_n     = '0;
            bit_idx_n = '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                cnt_n = '0;
                if (state == DATA) begin
                    shreg_n   = {1'b0, shreg[DATA_BITS-1:1]};
                    bit_idx_n = bit_idx + 3'd1;
                end
            end else begin
                cnt_n = cnt + 16'd1;
            end
        end
    end

    // Outputs are decoded from next-state values so the registered pins line up with the FSM.
    // Next state is IDLE only when the FIFO is empty and not popping, so only a push can refill it.
    always_comb begin
        case (state_n)
            START:   sout_n = ~IDLE_LEVEL;
            DATA:    sout_n = shreg_n[0];
            default: sout_n = IDLE_LEVEL;
        endcase
        busy_n = (state_n != IDLE) || (tx_valid && !fifo_full);
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: directed timing checks plus a randomised run scored by a mid-bit sampling receiver.
module tb_uart_tx_core;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] baud_div;
    logic        uart_sout;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_core #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .baud_div  (baud_div),
        .uart_sout (uart_sout),
        .busy      (busy)
    );

    int         checks = 0;
    int         fails  = 0;
    int         acc_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Level of bit k (0 = start, 1..8 = data LSB first, 9 = stop) of an 8N1 frame.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard input: every handshake accepted outside reset is expected on the line, in order.
    always @(posedge clk) begin
        if (rst === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            exp_q.push_back(tx_data);
            acc_cnt++;
        end
    end

    // Receiver model: detect start edge, then sample the middle of each bit period.
    logic        rx_active = 1'b0;
    int          rx_t;
    int          rx_b;
    int          rx_k;
    logic [7:0]  rx_byte;
    logic [15:0] baud_prev = '0;

    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            rx_active = 1'b0;
        end else begin
            if (!rx_active && uart_sout === 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
                rx_b      = int'(baud_prev) + 1;
                rx_byte   = '0;
                chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            end else if (rx_active) begin
                rx_t++;
            end
            if (rx_active && rx_t >= rx_b / 2 && ((rx_t - rx_b / 2) % rx_b) == 0) begin
                rx_k = (rx_t - rx_b / 2) / rx_b;
                if (rx_k == 0) begin
                    chk("start_bit", 32'(uart_sout), 32'd0);
                end else if (rx_k <= 8) begin
                    rx_byte[rx_k-1] = uart_sout;
                end else begin
                    chk("stop_bit", 32'(uart_sout), 32'd1);
                    if (exp_q.size() != 0) chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    rx_active = 1'b0;
                end
            end
        end
        baud_prev = baud_div;
    end

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || rx_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        logic       es;
        int         target;
        int         n;
        int         base;

        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        baud_div = 16'd0;

        // Reset with tx_valid held high: nothing may be accepted.
        repeat (3) tick();
        rst      = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("reset_sout", 32'(uart_sout), 32'd1);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (20) tick();
        chk("no_frame_after_reset", 32'(busy), 32'd0);

        // Single frame 0xA5, 4-cycle bits.
        baud_div = 16'd3;
        for (int c = 0; c < 46; c++) begin
            tick();
            tx_valid = (c == 0);
            tx_data  = 8'hA5;
            @(negedge clk);
            es = (c >= 2 && c < 42) ? frame_bit(8'hA5, (c - 2) / 4) : 1'b1;
            chk("a5_sout", 32'(uart_sout), 32'(es));
            chk("a5_busy", 32'(busy), 32'(c >= 1 && c < 42));
        end

        // Two 1-cycle-bit frames back to back.
        baud_div = 16'd0;
        for (int c = 0; c < 25; c++) begin
            tick();
            tx_valid = (c < 2);
            tx_data  = (c == 0) ? 8'h00 : 8'hFF;
            @(negedge clk);
            if (c >= 2 && c < 12)       es = frame_bit(8'h00, c - 2);
            else if (c >= 12 && c < 22) es = frame_bit(8'hFF, c - 12);
            else                        es = 1'b1;
            chk("b2b_sout", 32'(uart_sout), 32'(es));
            chk("b2b_busy", 32'(busy), 32'(c >= 1 && c < 22));
        end

        // FIFO fill with tx_valid held high.
        baud_div = 16'd9;
        base = acc_cnt;
        for (int c = 0; c < 104; c++) begin
            tick();
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            @(negedge clk);
            chk("fill_ready", 32'(tx_ready), 32'(c <= 4 || c == 102));
        end
        tick();
        tx_valid = 1'b0;
        chk("fill_accepted", 32'(acc_cnt - base), 32'd6);
        wait_idle(800, "fill_drain");

        // Reset during data bit 3 of a 0x3C frame.
        baud_div = 16'd7;
        for (int c = 0; c < 38; c++) begin
            tick();
            tx_valid = (c == 0);
            tx_data  = 8'h3C;
            if (c == 36) begin
                rst = 1'b1;
                exp_q.delete();
            end
            if (c == 37) rst = 1'b0;
            @(negedge clk);
            if (c == 35) chk("rst_pre_bit3", 32'(uart_sout), 32'(frame_bit(8'h3C, 4)));
        end
        chk("rst_sout", 32'(uart_sout), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (100) tick();
        chk("rst_no_frame", 32'(busy), 32'd0);

        // baud_div change mid-frame applies only to the next frame.
        baud_div = 16'd3;
        for (int c = 0; c < 206; c++) begin
            tick();
            tx_valid = (c < 2);
            tx_data  = (c == 0) ? 8'h96 : 8'h4B;
            if (c == 20) baud_div = 16'd15;
            @(negedge clk);
            if (c >= 2 && c < 42)        es = frame_bit(8'h96, (c - 2) / 4);
            else if (c >= 42 && c < 202) es = frame_bit(8'h4B, (c - 42) / 16);
            else                         es = 1'b1;
            chk("baud_sout", 32'(uart_sout), 32'(es));
            chk("baud_busy", 32'(busy), 32'(c >= 1 && c < 202));
        end

        // Randomised traffic: 4 phases x 250 bytes.
        for (int p = 0; p < 4; p++) begin
            tick();
            baud_div = 16'($urandom_range(0, 3));
            target   = acc_cnt + 250;
            n        = 0;
            while (acc_cnt < target && n < 20000) begin
                tx_valid = 1'($urandom_range(0, 1));
                tx_data  = 8'($urandom);
                tick();
                n++;
            end
            tx_valid = 1'b0;
            chk("rand_accepted", 32'(acc_cnt), 32'(target));
            wait_idle(12000, "rand_drain");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
